// File: rtl/spi.sv
// Receive-only SPI slave (mode 0, MSB first): oversamples the SPI pins on clk_sys
// and presents each completed frame as an opcode plus payload with a valid strobe.
`default_nettype none

module spi #(
  parameter int FRAME_BITS  = 88,
  parameter int OPCODE_BITS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk_sys,
  input  logic                             rstb,
  input  logic                             clk_spi,
  input  logic                             cs,
  input  logic                             spi_mosi,
  output logic [OPCODE_BITS-1:0]           opcode,
  output logic [FRAME_BITS-OPCODE_BITS-1:0] data_packed,
  output logic                             full,
  output logic                             valid
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] primed_sr;

  logic                   sclk_prev;
  logic                   cs_hi_prev;
  logic                   active;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  shift;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic primed;
  logic sclk_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign primed    = primed_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // primed_sr marks when the cs chain holds a real pin sample rather than its
  // reset value, so a cs held low across reset is not mistaken for a new frame.
  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      primed_sr <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], clk_spi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      primed_sr <= {primed_sr[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_sys or negedge rstb) begin
    if (!rstb) begin
      sclk_prev   <= 1'b0;
      cs_hi_prev  <= 1'b0;
      active      <= 1'b0;
      bit_cnt     <= '0;
      shift       <= '0;
      opcode      <= '0;
      data_packed <= '0;
      full        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      sclk_prev  <= sclk_s;
      cs_hi_prev <= primed & cs_s;
      if (cs_s) begin
        active  <= 1'b0;
        bit_cnt <= '0;
        full    <= 1'b0;
      end else if (cs_hi_prev) begin
        active  <= 1'b1;
        bit_cnt <= '0;
        full    <= 1'b0;
      end else if (active) begin
        if (sclk_rise && (bit_cnt < FRAME_CNT)) begin
          shift   <= {shift[FRAME_BITS-2:0], mosi_s};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        // Publish one cycle after the last bit lands so shift holds the whole frame.
        if ((bit_cnt == FRAME_CNT) && !full) begin
          opcode      <= shift[FRAME_BITS-1 -: OPCODE_BITS];
          data_packed <= shift[FRAME_BITS-OPCODE_BITS-1:0];
          valid       <= 1'b1;
          full        <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi.sv
// Directed bench for spi: queue-based frame model checked every clk_sys cycle,
// plus literal expectations and a valid-latency probe.
`default_nettype none

module tb_spi;

  logic        clk_sys = 1'b0;
  logic        rstb    = 1'b0;
  logic        clk_spi = 1'b0;
  logic        cs      = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [7:0]  opcode;
  logic [79:0] data_packed;
  logic        full;
  logic        valid;

  int tests = 0;
  int fails = 0;

  logic [87:0] exp_q[$];
  logic [87:0] last_frame = '0;
  logic        prev_valid = 1'b0;
  event        ev88;

  spi dut (
    .clk_sys    (clk_sys),
    .rstb       (rstb),
    .clk_spi    (clk_spi),
    .cs         (cs),
    .spi_mosi   (spi_mosi),
    .opcode     (opcode),
    .data_packed(data_packed),
    .full       (full),
    .valid      (valid)
  );

  always #9 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every frame of >= 88 bits yields exactly one valid carrying its first
  // 88 bits; between valids the outputs hold the last delivered frame.
  always @(negedge clk_sys) begin
    if (!rstb) begin
      chk("reset_outputs", {78'd0, opcode != 8'd0, data_packed != 80'd0, full, valid}, 88'd0);
      last_frame = '0;
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        chk("valid_width", {87'd0, prev_valid}, 88'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 88'd1, 88'd0);
        end else begin
          last_frame = exp_q.pop_front();
          chk("frame_on_valid", {opcode, data_packed}, last_frame);
        end
      end else begin
        chk("outputs_stable", {opcode, data_packed}, last_frame);
      end
      prev_valid = valid;
    end
  end

  // Valid must rise on the 3rd clk_sys edge after stage 1 first sees the 88th rise.
  initial begin
    forever begin
      @(ev88);
      @(posedge clk_sys);
      repeat (2) @(posedge clk_sys);
      #1 chk("latency_early", {87'd0, valid}, 88'd0);
      @(posedge clk_sys);
      #1 chk("latency_rise", {87'd0, valid}, 88'd1);
      @(posedge clk_sys);
      #1 chk("latency_fall", {87'd0, valid}, 88'd0);
    end
  end

  task automatic send(input logic [87:0] f, input int n);
    if (n >= 88) exp_q.push_back(f);
    cs = 1'b0;
    #60;
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 88) ? f[87-i] : 1'b1;
      #40 clk_spi = 1'b1;
      if (i == 87) -> ev88;
      #40 clk_spi = 1'b0;
    end
    #60;
    chk("full_before_cs_rise", {87'd0, full}, {87'd0, (n >= 88)});
    cs = 1'b1;
    spi_mosi = 1'b0;
    #80;
    chk("full_after_cs_rise", {87'd0, full}, 88'd0);
    chk("no_missing_valid", 88'(exp_q.size()), 88'd0);
    #40;
  endtask

  initial begin
    logic [87:0] f1, f2, f3, f4, f5;
    f1 = 88'hA5_0123456789ABCDEF0123;
    f2 = 88'h01_00112233445566778899;
    f3 = 88'h02_FFFFFFFFFFFFFFFFFFFF;
    f4 = 88'h3C_5A5A5A5A5A5A5A5A5A5A;
    f5 = 88'h7E_DEADBEEFCAFE12345678;

    #40 rstb = 1'b1;
    #40;
    chk("reset_opcode", {80'd0, opcode}, 88'd0);
    chk("reset_data", {8'd0, data_packed}, 88'd0);

    send(f1, 88);
    chk("cfg_opcode", {80'd0, opcode}, 88'hA5);
    chk("cfg_data", {8'd0, data_packed}, 88'h00_0123456789ABCDEF0123);

    send(f2, 88);
    chk("b2b1_opcode", {80'd0, opcode}, 88'h01);
    send(f3, 88);
    chk("b2b2_opcode", {80'd0, opcode}, 88'h02);
    chk("b2b2_data", {8'd0, data_packed}, {8'd0, {80{1'b1}}});

    send(f4, 40);
    chk("abort_opcode", {80'd0, opcode}, 88'h02);
    chk("abort_data", {8'd0, data_packed}, {8'd0, {80{1'b1}}});
    send(f4, 88);
    chk("after_abort_frame", {opcode, data_packed}, 88'h3C_5A5A5A5A5A5A5A5A5A5A);

    send(f5, 90);
    chk("extra_bits_frame", {opcode, data_packed}, 88'h7E_DEADBEEFCAFE12345678);

    // Reset at bit 50 with cs held low: no capture until a fresh cs fall.
    cs = 1'b0;
    #60;
    for (int i = 0; i < 50; i++) begin
      spi_mosi = f1[87-i];
      #40 clk_spi = 1'b1;
      #40 clk_spi = 1'b0;
    end
    rstb = 1'b0;
    #40 rstb = 1'b1;
    for (int i = 0; i < 90; i++) begin
      spi_mosi = f2[87-(i % 88)];
      #40 clk_spi = 1'b1;
      #40 clk_spi = 1'b0;
    end
    #60;
    chk("rst_hold_full", {87'd0, full}, 88'd0);
    cs = 1'b1;
    #80;
    chk("rst_opcode", {80'd0, opcode}, 88'd0);
    chk("rst_data", {8'd0, data_packed}, 88'd0);
    send(f1, 88);
    chk("post_rst_frame", {opcode, data_packed}, 88'hA5_0123456789ABCDEF0123);

    #100;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
